// File: rtl/mv_job_scheduler.sv
// mv_job_scheduler
// Sequences one matrix-vector job over the MAC array system. A job is a
// number of row-tile passes. The scheduler optionally clears the accumulators
// once, launches each pass, waits for the array to finish, and streams the
// captured accumulators out as one result beat per tile. It then pulses
// job_done. Only one job is in flight at a time.
//
// Parameters
//   ACC_W    accumulator lane width (four lanes per beat)
//   TILE_W   width of the tile count and the tile index
//   TIMEOUT  maximum WAIT cycles per tile before giving up (>= 2)
//
// Ports
//   clk, rst               clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready    job request handshake; cmd_ready is high only in IDLE
//   cmd_tiles, cmd_clear   pass count and "clear accumulators first" flag
//   abort                  synchronous cancel of the running job
//   arr_start, arr_clear   one-cycle pulses to the array system
//   arr_busy, arr_done     array status; arr_done is a one-cycle pulse
//   arr_acc                {acc_3, acc_2, acc_1, acc_0} from the array
//   res_valid/res_ready    result beat handshake
//   res_data, res_tile     captured accumulators and the tile index of the beat
//   res_last               marks the final beat of the job
//   busy, job_done         activity flag and one-cycle completion pulse
//   err_timeout            sticky flag: a pass never reported arr_done

module mv_job_scheduler #(
    parameter int ACC_W   = 16,
    parameter int TILE_W  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [TILE_W-1:0]   cmd_tiles,
    input  logic                cmd_clear,
    input  logic                abort,
    output logic                arr_start,
    output logic                arr_clear,
    input  logic                arr_busy,
    input  logic                arr_done,
    input  logic [4*ACC_W-1:0]  arr_acc,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [4*ACC_W-1:0]  res_data,
    output logic [TILE_W-1:0]   res_tile,
    output logic                res_last,
    output logic                busy,
    output logic                job_done,
    output logic                err_timeout
);

    localparam int              CNT_W   = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LAUNCH,
        WAIT,
        EMIT,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [TILE_W-1:0]  tiles_q;
    logic [TILE_W-1:0]  tile_idx;
    logic [CNT_W-1:0]   wait_cnt;
    logic               last_tile;
    logic               timeout_hit;
    logic               kill;

    // tiles_q is at least 1 whenever a pass runs (a zero-tile job goes
    // straight to DONE), so tiles_q - 1 never underflows here.
    assign last_tile   = (tile_idx == tiles_q - TILE_W'(1));
    assign timeout_hit = (wait_cnt == CNT_MAX);
    assign kill        = abort && (state != IDLE);

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign res_valid = (state == EMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The start and clear pulses are decoded from the state so that
    // arr_start can appear on the cycle right after acceptance. They are
    // suppressed during an abort so the array is never kicked off by a job
    // that is being cancelled.
    always_comb begin
        next_state = state;
        arr_start  = 1'b0;
        arr_clear  = 1'b0;
        if (kill) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_tiles == '0) begin
                            next_state = DONE;
                        end else if (cmd_clear) begin
                            next_state = CLEAR;
                        end else begin
                            next_state = LAUNCH;
                        end
                    end
                end
                CLEAR: begin
                    arr_clear  = 1'b1;
                    next_state = LAUNCH;
                end
                LAUNCH: begin
                    if (!arr_busy) begin
                        arr_start  = 1'b1;
                        next_state = WAIT;
                    end
                end
                WAIT: begin
                    if (arr_done) begin
                        next_state = EMIT;
                    end else if (timeout_hit) begin
                        next_state = DONE;
                    end
                end
                EMIT: begin
                    if (res_ready) begin
                        next_state = res_last ? DONE : LAUNCH;
                    end
                end
                DONE: begin
                    next_state = IDLE;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // job_done is registered off the DONE state, so it appears on the cycle
    // after DONE (two cycles after accepting a zero-tile job). The WAIT
    // counter is zeroed on every launch. arr_done is checked before the
    // timeout so that a completion on the last allowed cycle is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tiles_q     <= '0;
            tile_idx    <= '0;
            wait_cnt    <= '0;
            res_data    <= '0;
            res_tile    <= '0;
            res_last    <= 1'b0;
            job_done    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            job_done <= (state == DONE) && !abort;
            if (!kill) begin
                case (state)
                    IDLE: begin
                        if (cmd_valid) begin
                            tiles_q     <= cmd_tiles;
                            tile_idx    <= '0;
                            err_timeout <= 1'b0;
                        end
                    end
                    LAUNCH: begin
                        wait_cnt <= '0;
                    end
                    WAIT: begin
                        if (arr_done) begin
                            res_data <= arr_acc;
                            res_tile <= tile_idx;
                            res_last <= last_tile;
                        end else if (timeout_hit) begin
                            err_timeout <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        end
                    end
                    EMIT: begin
                        if (res_ready && !res_last) begin
                            tile_idx <= tile_idx + TILE_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/mv_job_scheduler.md
MV_JOB_SCHEDULER -- requirements
Module: mv_job_scheduler

Interface
REQ-001 SHALL have parameter ACC_W, default 16, accumulator lane width.
REQ-002 SHALL have parameter TILE_W, default 4, width of tile count and tile index.
REQ-003 SHALL have parameter TIMEOUT, default 1024, maximum WAIT cycles per tile, >=2.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; all other logic is synchronous to clk.
REQ-005 SHALL have port clk  input  1  clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous reset, active low.
REQ-007 SHALL have port cmd_valid  input  1  host job request.
REQ-008 SHALL have port cmd_ready  output  1  scheduler accepts a job.
REQ-009 SHALL have port cmd_tiles  input  TILE_W  number of row-tile passes in the job.
REQ-010 SHALL have port cmd_clear  input  1  clear accumulators before the first pass.
REQ-011 SHALL have port abort  input  1  synchronous job cancel.
REQ-012 SHALL have port arr_start  output  1  one-cycle start pulse to the MAC array system.
REQ-013 SHALL have port arr_clear  output  1  one-cycle accumulator clear.
REQ-014 SHALL have port arr_busy  input  1  array system busy.
REQ-015 SHALL have port arr_done  input  1  array pass complete, one-cycle pulse.
REQ-016 SHALL have port arr_acc  input  4*ACC_W  {acc_3,acc_2,acc_1,acc_0}.
REQ-017 SHALL have port res_valid  output  1  result beat valid.
REQ-018 SHALL have port res_ready  input  1  sink accepts the beat.
REQ-019 SHALL have port res_data  output  4*ACC_W  captured accumulators.
REQ-020 SHALL have port res_tile  output  TILE_W  tile index of the beat.
REQ-021 SHALL have port res_last  output  1  final beat of the job.
REQ-022 SHALL have port busy  output  1  state is not IDLE.
REQ-023 SHALL have port job_done  output  1  one-cycle completion pulse.
REQ-024 SHALL have port err_timeout  output  1  sticky timeout flag.

Function
REQ-025 SHALL implement the FSM states IDLE, CLEAR, LAUNCH, WAIT, EMIT and DONE.
REQ-026 IDLE: cmd_ready=1; on cmd_valid, SHALL latch cmd_tiles and cmd_clear, set tile_idx=0, clear err_timeout, and go to DONE if tiles==0, else CLEAR if clear=1, else LAUNCH.
REQ-027 cmd_ready SHALL be 0 in every non-IDLE state, so no commands are queued.
REQ-028 CLEAR SHALL assert arr_clear for exactly one cycle and then go to LAUNCH.
REQ-029 LAUNCH SHALL assert arr_start for one cycle only when arr_busy=0 and then go to WAIT; while arr_busy=1 it SHALL hold with arr_start=0.
REQ-030 Latency: command accepted at cycle T SHALL give arr_start at T+1 without clear, or T+2 with clear, when arr_busy=0.
REQ-031 WAIT SHALL count cycles from 0; on arr_done it SHALL register arr_acc into res_data and go to EMIT, so res_valid rises on the next cycle.
REQ-032 WAIT timeout: when the count reaches TIMEOUT-1 with no arr_done, the block SHALL set err_timeout and go to DONE without emitting a beat.
REQ-033 If arr_done and timeout occur in the same cycle, arr_done SHALL win.
REQ-034 arr_done outside WAIT SHALL be ignored.
REQ-035 EMIT SHALL hold res_valid=1 with res_data, res_tile=tile_idx and res_last=(tile_idx==tiles-1) stable until res_ready=1.
REQ-036 On an EMIT handshake, the block SHALL go to DONE if it is the last tile; otherwise it SHALL increment tile_idx and go to LAUNCH.
REQ-037 Later passes SHALL NOT pulse arr_clear, so accumulation continues across tiles.
REQ-038 DONE SHALL pulse job_done for one cycle and then go to IDLE.
REQ-039 job_done SHALL also fire for tiles==0 and for timeout.
REQ-040 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, deassert all pulses and res_valid, and not pulse job_done.
REQ-041 abort SHALL take priority over every other transition; abort in IDLE SHALL have no effect and SHALL NOT block command acceptance.
REQ-042 err_timeout SHALL stay set until the next accepted command or reset.
REQ-043 tile_idx SHALL never wrap; a maximum cmd_tiles of 2^TILE_W-1 SHALL complete normally.
REQ-044 busy SHALL be high in every state except IDLE, including DONE.

Reset
REQ-045 rst low SHALL immediately put the FSM in IDLE.
REQ-046 rst low SHALL clear to 0: tile_idx, the WAIT counter, res_data, res_tile, res_last, res_valid, arr_start, arr_clear, job_done, err_timeout and busy.
REQ-047 rst low SHALL set cmd_ready=1 once the FSM is in IDLE.
REQ-048 Reset asserted mid-job SHALL abandon the job with no job_done and no result beat.

Verification
REQ-049 tiles=3, clear=1, arr_done 5 cycles after each start, res_ready=1 -> one arr_clear, then 3 arr_start pulses, beats res_tile 0,1,2 with res_last only on 2, then one job_done.
REQ-050 tiles=2, res_ready low for 4 cycles on beat 0 -> res_data and res_tile stable throughout, second arr_start only after the handshake.
REQ-051 arr_busy=1 for 6 cycles at launch -> arr_start held off, then issued on the first cycle with arr_busy=0.
REQ-052 TIMEOUT=8 with no arr_done -> err_timeout=1 after 8 WAIT cycles, job_done pulse, no res_valid; the next command clears err_timeout.
REQ-053 tiles=0 -> job_done 2 cycles after acceptance, no arr_start.
REQ-054 abort during WAIT, and separately rst low during EMIT -> IDLE, res_valid=0, no job_done; a new command is then accepted normally.
